// File: rtl/hacd_axi_ram_responder.sv
// hacd_axi_ram_responder: AXI4 slave backed by an on-chip word array.
// The write engine and the read engine each track one burst at a time and run
// independently of each other. FIXED, INCR and WRAP bursts are supported, and
// writes honour byte strobes. Upper address bits are ignored, so the array
// aliases across the whole address space.

`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif

module hacd_axi_ram_responder #(
    parameter int DATA_WIDTH     = `HACD_AXI4_DATA_WIDTH,
    parameter int ADDR_WIDTH     = `HACD_AXI4_ADDR_WIDTH,
    parameter int ID_WIDTH       = `HACD_AXI4_ID_WIDTH + 1,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready
);

    localparam int OFFS = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_ADDR_WIDTH)-1];

    wstate_t               w_state, w_next;
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] w_addr, w_addr_nxt;
    logic [7:0]            aw_len, w_cnt;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  w_err;
    logic                  aw_hs, w_hs, b_hs;
    logic [MEM_ADDR_WIDTH-1:0] w_idx;

    rstate_t               r_state, r_next;
    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] r_addr, r_addr_nxt;
    logic [7:0]            ar_len, r_cnt;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  r_err;
    logic                  ar_hs, r_hs;
    logic [MEM_ADDR_WIDTH-1:0] ar_idx, r_idx_nxt;

    // Address of the beat after this one; WRAP stays inside the aligned
    // (len+1)<<size window, reserved burst type behaves like INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] sum;
        step = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        sum  = addr + step;
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | (sum & mask);
            default: next_addr = sum;
        endcase
    endfunction

    assign aw_hs      = s_axi_awvalid && s_axi_awready;
    assign w_hs       = s_axi_wvalid && s_axi_wready;
    assign b_hs       = s_axi_bvalid && s_axi_bready;
    assign ar_hs      = s_axi_arvalid && s_axi_arready;
    assign r_hs       = s_axi_rvalid && s_axi_rready;
    assign w_addr_nxt = next_addr(w_addr, aw_len, aw_size, aw_burst);
    assign r_addr_nxt = next_addr(r_addr, ar_len, ar_size, ar_burst);
    assign w_idx      = w_addr[MEM_ADDR_WIDTH+OFFS-1:OFFS];
    assign ar_idx     = s_axi_araddr[MEM_ADDR_WIDTH+OFFS-1:OFFS];
    assign r_idx_nxt  = r_addr_nxt[MEM_ADDR_WIDTH+OFFS-1:OFFS];

    assign s_axi_bid   = aw_id;
    assign s_axi_bresp = {w_err, 1'b0};
    assign s_axi_rid   = ar_id;
    assign s_axi_rresp = {r_err, 1'b0};

    // Write engine next state: address, then beats until beat awlen, then response.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && (w_cnt == aw_len)) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write state register; handshake outputs are registered from the next state
    // so they stay low throughout reset and rise on the first edge after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
        end else begin
            w_state       <= w_next;
            s_axi_awready <= (w_next == W_IDLE);
            s_axi_wready  <= (w_next == W_DATA);
            s_axi_bvalid  <= (w_next == W_RESP);
        end
    end

    // Write burst bookkeeping: latch the request, step address and beat count,
    // and flag SLVERR for a reserved burst type or a misplaced wlast.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_id    <= '0;
            w_addr   <= '0;
            aw_len   <= '0;
            aw_size  <= '0;
            aw_burst <= '0;
            w_err    <= 1'b0;
            w_cnt    <= '0;
        end else if (aw_hs) begin
            aw_id    <= s_axi_awid;
            w_addr   <= s_axi_awaddr;
            aw_len   <= s_axi_awlen;
            aw_size  <= s_axi_awsize;
            aw_burst <= s_axi_awburst;
            w_err    <= (s_axi_awburst == 2'b11);
            w_cnt    <= '0;
        end else if (w_hs) begin
            w_addr <= w_addr_nxt;
            w_cnt  <= w_cnt + 8'd1;
            if (s_axi_wlast != (w_cnt == aw_len)) begin
                w_err <= 1'b1;
            end
        end
    end

    // Array write port: only strobed byte lanes of the current word change.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read engine next state: leave R_DATA only after the rlast handshake.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && s_axi_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read state register with registered arready/rvalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
        end else begin
            r_state       <= r_next;
            s_axi_arready <= (r_next == R_IDLE);
            s_axi_rvalid  <= (r_next == R_DATA);
        end
    end

    // Read burst bookkeeping: fetch a word on AR and on each non-final R
    // handshake; nothing moves while the master stalls, keeping R stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_id       <= '0;
            r_addr      <= '0;
            ar_len      <= '0;
            ar_size     <= '0;
            ar_burst    <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            s_axi_rdata <= '0;
            s_axi_rlast <= 1'b0;
        end else if (ar_hs) begin
            ar_id       <= s_axi_arid;
            r_addr      <= s_axi_araddr;
            ar_len      <= s_axi_arlen;
            ar_size     <= s_axi_arsize;
            ar_burst    <= s_axi_arburst;
            r_err       <= (s_axi_arburst == 2'b11);
            r_cnt       <= '0;
            s_axi_rdata <= mem[ar_idx];
            s_axi_rlast <= (s_axi_arlen == 8'd0);
        end else if (r_hs) begin
            if (s_axi_rlast) begin
                s_axi_rlast <= 1'b0;
            end else begin
                r_addr      <= r_addr_nxt;
                r_cnt       <= r_cnt + 8'd1;
                s_axi_rdata <= mem[r_idx_nxt];
                s_axi_rlast <= ((r_cnt + 8'd1) == ar_len);
            end
        end
    end

endmodule

// File: tb/tb_hacd_axi_ram_responder.sv
// tb_hacd_axi_ram_responder: directed vectors plus multi-beat sequences for
// the AXI RAM responder, with hand-computed expected values.

module tb_hacd_axi_ram_responder;

    logic        clk;
    logic        rst;
    logic [4:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [4:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic [4:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [4:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    int testCount = 0;
    int failCount = 0;

    logic [63:0] wbuf [16];
    logic [63:0] rbuf [16];
    logic        rlastBuf [16];
    logic [1:0]  rrespBuf [16];
    logic [4:0]  ridBuf [16];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [7:0]  strb;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [63:0] expData;
        logic [1:0]  expResp;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    hacd_axi_ram_responder #(
        .DATA_WIDTH(64), .ADDR_WIDTH(32), .ID_WIDTH(5), .MEM_ADDR_WIDTH(10), .STRB_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bid(bid), .s_axi_bresp(bresp),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeoutFail(input string name);
        testCount++;
        failCount++;
        $display("[TB] FAIL %s: timed out waiting for handshake", name);
    endtask

    // Full write burst (size 8 bytes); called and returns at a negedge.
    task automatic doWrite(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [7:0] strb, input int earlyLast,
                           input int bHold, output logic [1:0] resp, output logic [4:0] gotId,
                           output int bLate);
        int guard;
        resp = 2'b11;
        gotId = '0;
        bLate = 99;
        awid = id; awaddr = addr; awlen = len; awsize = 3'd3; awburst = burst; awvalid = 1'b1;
        guard = 0;
        while (!awready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin awvalid = 1'b0; timeoutFail("aw"); return; end
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wbuf[i];
            wstrb = strb;
            wlast = (earlyLast != 0) ? (i == 0) : (i == int'(len));
            wvalid = 1'b1;
            guard = 0;
            while (!wready && guard < 50) begin @(negedge clk); guard++; end
            if (guard >= 50) begin wvalid = 1'b0; timeoutFail("w"); return; end
            @(negedge clk);
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        bLate = 0;
        while (!bvalid && bLate < 50) begin @(negedge clk); bLate++; end
        if (bLate >= 50) begin timeoutFail("b"); return; end
        for (int k = 0; k < bHold; k++) begin
            checkOutput("b_hold_valid", 64'(bvalid), 64'd1);
            checkOutput("b_hold_id", 64'(bid), 64'(id));
            @(negedge clk);
        end
        resp = bresp;
        gotId = bid;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        checkOutput("b_done_bvalid", 64'(bvalid), 64'd0);
        checkOutput("b_done_awready", 64'(awready), 64'd1);
    endtask

    // Full read burst (size 8 bytes); toggle!=0 drives rready 1,0,1,0,...
    task automatic doRead(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int toggle, output int firstLate);
        int guard;
        int beat;
        int cyc;
        bit stalled;
        logic [63:0] hData;
        logic hLast;
        logic [4:0] hId;
        firstLate = 99;
        arid = id; araddr = addr; arlen = len; arsize = 3'd3; arburst = burst; arvalid = 1'b1;
        guard = 0;
        while (!arready && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) begin arvalid = 1'b0; timeoutFail("ar"); return; end
        @(negedge clk);
        arvalid = 1'b0;
        firstLate = rvalid ? 0 : 1;
        beat = 0; cyc = 0; guard = 0; stalled = 1'b0;
        hData = '0; hLast = 1'b0; hId = '0;
        while (beat <= int'(len) && guard < 200) begin
            if (stalled) begin
                checkOutput("r_stall_valid", 64'(rvalid), 64'd1);
                checkOutput("r_stall_data", rdata, hData);
                checkOutput("r_stall_last", 64'(rlast), 64'(hLast));
                checkOutput("r_stall_id", 64'(rid), 64'(hId));
            end
            rready = (toggle != 0 && (cyc % 2) == 1) ? 1'b0 : 1'b1;
            stalled = 1'b0;
            if (rvalid && rready) begin
                rbuf[beat] = rdata;
                rlastBuf[beat] = rlast;
                rrespBuf[beat] = rresp;
                ridBuf[beat] = rid;
                beat++;
            end else if (rvalid) begin
                stalled = 1'b1;
                hData = rdata; hLast = rlast; hId = rid;
            end
            @(negedge clk);
            cyc++;
            guard++;
        end
        rready = 1'b0;
        if (beat <= int'(len)) begin timeoutFail("r"); return; end
        checkOutput("r_done_rvalid", 64'(rvalid), 64'd0);
        checkOutput("r_done_arready", 64'(arready), 64'd1);
    endtask

    // One single-beat table vector: write checks B, read checks R.
    task automatic applyStimulus(input int idx, input vec_t v);
        logic [1:0] resp;
        logic [4:0] gid;
        int late;
        if (v.wr) begin
            wbuf[0] = v.data;
            doWrite(5'(idx), v.addr, 8'd0, v.burst, v.strb, 0, 0, resp, gid, late);
            checkOutput($sformatf("vec%0d_bresp", idx), 64'(resp), 64'(v.expResp));
            checkOutput($sformatf("vec%0d_bid", idx), 64'(gid), 64'(idx));
            checkOutput($sformatf("vec%0d_b_latency", idx), 64'(late), 64'd0);
        end else begin
            doRead(5'(idx), v.addr, 8'd0, v.burst, 0, late);
            checkOutput($sformatf("vec%0d_rdata", idx), rbuf[0], v.expData);
            checkOutput($sformatf("vec%0d_rresp", idx), 64'(rrespBuf[0]), 64'(v.expResp));
            checkOutput($sformatf("vec%0d_rid", idx), 64'(ridBuf[0]), 64'(idx));
            checkOutput($sformatf("vec%0d_rlast", idx), 64'(rlastBuf[0]), 64'd1);
            checkOutput($sformatf("vec%0d_r_latency", idx), 64'(late), 64'd0);
        end
    endtask

    initial begin
        logic [1:0]  resp, resp2;
        logic [4:0]  gid, gid2;
        int          late, late2, rlate;
        logic [63:0] expWrap [4];

        rst = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;

        vecs[0] = '{1'b1, 32'h40,   8'hFF, 2'b01, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 2'b00};
        vecs[1] = '{1'b0, 32'h40,   8'h00, 2'b01, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00};
        vecs[2] = '{1'b1, 32'h100,  8'hFF, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'b00};
        vecs[3] = '{1'b1, 32'h100,  8'h01, 2'b01, 64'h3333_3333_3333_3312, 64'h0, 2'b00};
        vecs[4] = '{1'b1, 32'h100,  8'h80, 2'b01, 64'h5A44_4444_4444_4444, 64'h0, 2'b00};
        vecs[5] = '{1'b0, 32'h100,  8'h00, 2'b01, 64'h0, 64'h5AFF_FFFF_FFFF_FF12, 2'b00};
        vecs[6] = '{1'b1, 32'h200,  8'hFF, 2'b11, 64'h0000_0000_0000_1234, 64'h0, 2'b10};
        vecs[7] = '{1'b0, 32'h200,  8'h00, 2'b11, 64'h0, 64'h0000_0000_0000_1234, 2'b10};
        vecs[8] = '{1'b0, 32'h2040, 8'h00, 2'b01, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00};
        vecs[9] = '{1'b0, 32'h40,   8'h00, 2'b00, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 2'b00};

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_awready", 64'(awready), 64'd0);
        checkOutput("rst_wready", 64'(wready), 64'd0);
        checkOutput("rst_bvalid", 64'(bvalid), 64'd0);
        checkOutput("rst_arready", 64'(arready), 64'd0);
        checkOutput("rst_rvalid", 64'(rvalid), 64'd0);
        checkOutput("rst_rlast", 64'(rlast), 64'd0);
        checkOutput("rst_bid", 64'(bid), 64'd0);
        checkOutput("rst_bresp", 64'(bresp), 64'd0);
        checkOutput("rst_rid", 64'(rid), 64'd0);
        checkOutput("rst_rresp", 64'(rresp), 64'd0);
        checkOutput("rst_rdata", rdata, 64'd0);
        rst = 1'b0;
        #1;
        checkOutput("awready_before_edge", 64'(awready), 64'd0);
        @(negedge clk);
        checkOutput("awready_after_edge", 64'(awready), 64'd1);
        checkOutput("arready_after_edge", 64'(arready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // INCR len 3 write of 1..4, read back with rready toggling.
        for (int i = 0; i < 4; i++) wbuf[i] = 64'(i + 1);
        doWrite(5'h11, 32'h0, 8'd3, 2'b01, 8'hFF, 0, 0, resp, gid, late);
        checkOutput("incr_bresp", 64'(resp), 64'd0);
        checkOutput("incr_bid", 64'(gid), 64'h11);
        doRead(5'h12, 32'h0, 8'd3, 2'b01, 1, rlate);
        checkOutput("incr_r_latency", 64'(rlate), 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("incr_rdata%0d", i), rbuf[i], 64'(i + 1));
            checkOutput($sformatf("incr_rlast%0d", i), 64'(rlastBuf[i]), 64'(i == 3));
            checkOutput($sformatf("incr_rid%0d", i), 64'(ridBuf[i]), 64'h12);
        end

        // WRAP len 3 starting at word 2: lands on words 2,3,0,1.
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hC1 + 64'(i);
        doWrite(5'h13, 32'h10, 8'd3, 2'b10, 8'hFF, 0, 0, resp, gid, late);
        checkOutput("wrap_bresp", 64'(resp), 64'd0);
        expWrap[0] = 64'hC3; expWrap[1] = 64'hC4; expWrap[2] = 64'hC1; expWrap[3] = 64'hC2;
        doRead(5'h14, 32'h0, 8'd3, 2'b01, 0, rlate);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wrap_incr_rdata%0d", i), rbuf[i], expWrap[i]);
        end
        doRead(5'h15, 32'h18, 8'd3, 2'b10, 0, rlate);
        checkOutput("wrap_read0", rbuf[0], 64'hC2);
        checkOutput("wrap_read1", rbuf[1], 64'hC3);
        checkOutput("wrap_read2", rbuf[2], 64'hC4);
        checkOutput("wrap_read3", rbuf[3], 64'hC1);
        checkOutput("wrap_read_rlast3", 64'(rlastBuf[3]), 64'd1);

        // Early wlast on a len 1 burst, and a FIXED burst overwriting one word.
        wbuf[0] = 64'h77; wbuf[1] = 64'h78;
        doWrite(5'h16, 32'h500, 8'd1, 2'b01, 8'hFF, 1, 0, resp, gid, late);
        checkOutput("early_wlast_bresp", 64'(resp), 64'h2);
        wbuf[0] = 64'h61; wbuf[1] = 64'h62; wbuf[2] = 64'h63;
        doWrite(5'h1A, 32'h600, 8'd2, 2'b00, 8'hFF, 0, 0, resp, gid, late);
        checkOutput("fixed_bresp", 64'(resp), 64'd0);
        doRead(5'h1B, 32'h600, 8'd0, 2'b01, 0, rlate);
        checkOutput("fixed_rdata", rbuf[0], 64'h63);

        // Concurrent len 7 write (B stalled 5 cycles) and len 7 read.
        for (int i = 0; i < 8; i++) wbuf[i] = 64'hE0 + 64'(i);
        doWrite(5'h17, 32'h400, 8'd7, 2'b01, 8'hFF, 0, 0, resp, gid, late);
        for (int i = 0; i < 8; i++) wbuf[i] = 64'hF0 + 64'(i);
        fork
            doWrite(5'h18, 32'h300, 8'd7, 2'b01, 8'hFF, 0, 5, resp2, gid2, late2);
            doRead(5'h19, 32'h400, 8'd7, 2'b01, 0, rlate);
        join
        checkOutput("conc_bresp", 64'(resp2), 64'd0);
        checkOutput("conc_bid", 64'(gid2), 64'h18);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("conc_rdata%0d", i), rbuf[i], 64'hE0 + 64'(i));
        end
        checkOutput("conc_rlast7", 64'(rlastBuf[7]), 64'd1);
        checkOutput("conc_rlast6", 64'(rlastBuf[6]), 64'd0);
        doRead(5'h1C, 32'h300, 8'd7, 2'b01, 0, rlate);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("conc_back%0d", i), rbuf[i], 64'hF0 + 64'(i));
        end

        // Reset in the middle of a read burst.
        arid = 5'h1D; araddr = 32'h400; arlen = 8'd7; arsize = 3'd3; arburst = 2'b01;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        rready = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrd_rvalid", 64'(rvalid), 64'd1);
        checkOutput("midrd_rdata", rdata, 64'hE2);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_rvalid", 64'(rvalid), 64'd0);
        checkOutput("midrst_arready", 64'(arready), 64'd0);
        checkOutput("midrst_rlast", 64'(rlast), 64'd0);
        rready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postrst_arready", 64'(arready), 64'd1);
        checkOutput("postrst_rvalid", 64'(rvalid), 64'd0);
        doRead(5'h1E, 32'h40, 8'd0, 2'b01, 0, rlate);
        checkOutput("postrst_rdata", rbuf[0], 64'hA5A5_A5A5_A5A5_A5A5);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
